dmac_req_sequencer: RTL

Control sequencer placed directly upstream of the DMAC main datapath. It arbitrates the two peripheral request lines, then fetches the peripheral's four-word channel descriptor over the AHB master port (read-only, pipelined single transfers). It produces the register load enables, connection select, and channel enables that the datapath consumes, and returns to idle when the active channel raises its interrupt.

---
 rtl/dmac_req_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmac_req_sequencer.sv
// Request arbiter and descriptor-fetch sequencer in front of the DMAC datapath.
// Picks a peripheral request, reads its four-word channel descriptor over the
// AHB master port, then hands the port to the selected channel until its irq.
module dmac_req_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DmacReq,
  input  logic       HReady,
  input  logic [1:0] M_HResp,
  input  logic       irq,
  output logic       DmacReq_Reg_en,
  output logic       PeriAddr_reg_en,
  output logic       SAddr_Reg_en,
  output logic       DAddr_Reg_en,
  output logic       Trans_sz_Reg_en,
  output logic       Ctrl_Reg_en,
  output logic [1:0] addr_inc_sel,
  output logic [1:0] config_HTrans,
  output logic       config_write,
  output logic [1:0] con_sel,
  output logic       con_en,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] DESC_WORDS = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(3);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [1:0] SEL_CH1 = 2'b00;
  localparam logic [1:0] SEL_CH2 = 2'b01;
  localparam logic [1:0] SEL_CFG = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] addr_cnt, addr_cnt_next;
  logic [CNT_W-1:0] data_cnt, data_cnt_next;
  logic [1:0]       ch, ch_next;
  logic [1:0]       con_sel_q;
  logic             err_next;
  logic             addr_pending;
  logic             data_pending;
  logic [3:0]       word_en;

  // State, fetch counters, selected channel, sticky error and last con_sel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      ch        <= SEL_CH1;
      err       <= 1'b0;
      con_sel_q <= SEL_CFG;
    end else begin
      state     <= state_next;
      addr_cnt  <= addr_cnt_next;
      data_cnt  <= data_cnt_next;
      ch        <= ch_next;
      err       <= err_next;
      con_sel_q <= con_sel;
    end
  end

  assign addr_pending = (addr_cnt < DESC_WORDS);
  assign data_pending = (data_cnt < addr_cnt);

  // Next-state and per-cycle control decode; AHB pipeline tracked by the two counters.
  always_comb begin
    state_next      = state;
    addr_cnt_next   = addr_cnt;
    data_cnt_next   = data_cnt;
    ch_next         = ch;
    err_next        = err;
    DmacReq_Reg_en  = 1'b0;
    PeriAddr_reg_en = 1'b0;
    word_en         = 4'b0000;
    addr_inc_sel    = 2'b00;
    config_HTrans   = HTRANS_IDLE;
    con_sel         = SEL_CFG;
    channel_en_1    = 1'b0;
    channel_en_2    = 1'b0;

    case (state)
      S_IDLE: begin
        // Gated by rst so the capture strobes stay low while reset is held.
        if (rst && (DmacReq != 2'b00)) begin
          DmacReq_Reg_en  = 1'b1;
          PeriAddr_reg_en = 1'b1;
          ch_next         = DmacReq[1] ? SEL_CH2 : SEL_CH1;
          err_next        = 1'b0;
          addr_cnt_next   = '0;
          data_cnt_next   = '0;
          state_next      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (data_pending && (M_HResp == HRESP_ERROR)) begin
          // Either cycle of the two-cycle error response aborts the fetch.
          err_next   = 1'b1;
          state_next = S_ERR;
        end else begin
          if (addr_pending) begin
            config_HTrans = HTRANS_NONSEQ;
            addr_inc_sel  = addr_cnt[1:0];
            if (HReady) begin
              addr_cnt_next = addr_cnt + CNT_W'(1);
            end
          end
          if (data_pending && HReady) begin
            word_en       = 4'(1) << data_cnt[1:0];
            data_cnt_next = data_cnt + CNT_W'(1);
            if (data_cnt == LAST_WORD) begin
              state_next = S_RUN;
            end
          end
        end
      end

      S_RUN: begin
        con_sel      = ch;
        channel_en_1 = (ch == SEL_CH1);
        channel_en_2 = (ch == SEL_CH2);
        if (irq) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      S_ERR: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign SAddr_Reg_en    = word_en[0];
  assign DAddr_Reg_en    = word_en[1];
  assign Trans_sz_Reg_en = word_en[2];
  assign Ctrl_Reg_en     = word_en[3];
  assign config_write    = 1'b0;
  assign con_en          = (con_sel != con_sel_q);
  assign busy            = (state != S_IDLE);

endmodule
